aes_cbc_enc_ctrl: RTL and testbench
===================================

// Module: aes_cbc_enc_ctrl
// PURPOSE
//  Sequencer upstream of the encryption core. Accepts 128-bit plaintext blocks on a valid/ready stream.
//  Applies ECB or CBC chaining and drives the core's plain_text/start handshake.
//  Captures cipher_text on done_enc and returns it on a valid/ready output stream.
//  Key loading stays with key_expansion; this block only drives start/plain_text and observes ready_enc/done_enc.
// PARAMETERS
//  TIMEOUT_CYCLES  64   max cycles in WAIT_DONE before the block is aborted (>=16)
//  CNT_W           $clog2(TIMEOUT_CYCLES+1)  derived, width of the timeout counter
// PORTS
//  clk          in   1    single clock, rising edge
//  reset_n      in   1    asynchronous active-low reset
//  cbc_en       in   1    1=CBC, 0=ECB; sampled at block acceptance
//  iv_load      in   1    load iv_in into chain register (honoured in IDLE only)
//  iv_in        in   128  initialisation vector
//  in_valid     in   1    plaintext block valid
//  in_data      in   128  plaintext block
//  in_ready     out  1    block can be accepted
//  out_valid    out  1    ciphertext block valid
//  out_data     out  128  ciphertext block
//  out_ready    in   1    downstream accepts ciphertext
//  plain_text   out  128  to core plain_text
//  start        out  1    to core start, single-cycle pulse
//  ready_enc    in   1    core idle / key ready
//  done_enc     in   1    core done pulse; cipher_text valid while high
//  cipher_text  in   128  from core
//  timeout_err  out  1    sticky, set on timeout
//  clr_err      in   1    clears timeout_err
//  blk_cnt      out  32   completed blocks, wraps at 2^32-1 -> 0
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0 in reset, 1 in IDLE after reset; start=0; out_valid=0.
//  Reset also clears out_data, plain_text, chain, timeout_err and blk_cnt to 0.
//  FSM IDLE -> LAUNCH -> WAIT_DONE -> OUTPUT -> IDLE; all outputs registered.
//  IDLE: in_ready=1. Handshake in_valid&in_ready latches the block.
//   plain_text <= cbc_en ? in_data^chain : in_data; go to LAUNCH.
//  iv_load in IDLE: chain<=iv_in. If iv_load and in_valid fire in the same cycle, the new IV is XORed into that block.
//   iv_load outside IDLE is ignored.
//  LAUNCH: hold plain_text; when ready_enc=1, assert start for exactly one cycle and go to WAIT_DONE.
//   Otherwise wait indefinitely with start=0.
//  WAIT_DONE: start=0; timeout counter increments each cycle.
//   At the posedge with done_enc=1: out_data<=cipher_text; chain<=cipher_text if the block was CBC; out_valid<=1; go to OUTPUT.
//   If the counter reaches TIMEOUT_CYCLES: timeout_err<=1, block dropped, chain unchanged, go to IDLE.
//  OUTPUT: out_valid held with out_data stable until out_ready=1.
//   On that cycle out_valid<=0, blk_cnt+=1 (wrapping), next state IDLE.
//   Back-pressure of any length is legal; in_ready=0 throughout.
//  done_enc outside WAIT_DONE is ignored.
//  clr_err clears timeout_err; if clr_err coincides with a timeout, set wins.
//  Latency: acceptance -> start is at least 2 cycles; done_enc -> out_valid is 1 cycle.
//  Reset mid-operation: immediate return to reset values; the in-flight block and chain are discarded.
// STRUCTURE
//  Shared package aes_pkg: typedef logic [127:0] aes_block_t; enum state_t {IDLE, LAUNCH, WAIT_DONE, OUTPUT}.
//  Single module. The timeout counter may optionally be split into sub-module aes_timeout_cnt.
// TESTING (key_expansion loaded with 2b7e151628aed2a6abf7158809cf4f3c unless noted)
//  1 ECB: cbc_en=0, in 3243f6a8885a308d313198a2e0370734 -> out 3925841d02dc09fbdc118597196a0b32, blk_cnt=1.
//  2 CBC, IV 000102030405060708090a0b0c0d0e0f:
//    in 6bc1bee22e409f96e93d7e117393172a -> out 7649abac8119b246cee98e9b12e9197d;
//    in ae2d8a571e03ac9c9eb76fac45af8e51 -> out 5086cb9b507219ee95db113a917678b2.
//  3 Back-pressure: out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0,
//    exactly one output beat, blk_cnt+1 only.
//  4 Launch gating: hold ready_enc=0 for 10 cycles (stub core) -> start stays 0;
//    exactly one 1-cycle start pulse after ready_enc rises.
//  5 Timeout: stub core never asserts done_enc -> timeout_err=1 after 64 cycles, back to IDLE, no output.
//    clr_err clears it; the next block completes normally.
//  6 Async reset asserted in WAIT_DONE -> all outputs return to reset values immediately;
//    the post-reset ECB vector of test 1 passes.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared block type and sequencer state encoding for the AES datapath
package aes_pkg;
    typedef logic [127:0] aes_block_t;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, OUTPUT} state_t;
endpackage

// File: rtl/aes_timeout_cnt.sv
// aes_timeout_cnt: counts cycles while enabled and flags the last allowed cycle
module aes_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic hit
);
    logic [CNT_W-1:0] cnt;
    // restart from zero whenever the wait window is not active
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= en ? cnt + CNT_W'(1) : '0;
    end
    assign hit = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/aes_cbc_enc_ctrl.sv
// aes_cbc_enc_ctrl: ECB/CBC sequencer feeding the AES core over a valid/ready stream
module aes_cbc_enc_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cbc_en,
    input  logic         iv_load,
    input  aes_block_t   iv_in,
    input  logic         in_valid,
    input  aes_block_t   in_data,
    output logic         in_ready,
    output logic         out_valid,
    output aes_block_t   out_data,
    input  logic         out_ready,
    output aes_block_t   plain_text,
    output logic         start,
    input  logic         ready_enc,
    input  logic         done_enc,
    input  aes_block_t   cipher_text,
    output logic         timeout_err,
    input  logic         clr_err,
    output logic [31:0]  blk_cnt
);
    state_t     state_q, state_d;
    aes_block_t chain;
    logic       cbc_q, accept, launch, fin, drop, drain, to_hit;

    aes_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_to (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_q == WAIT_DONE),
        .hit     (to_hit)
    );

    // transition events and next state; in_ready is only ever high in IDLE
    always_comb begin
        accept  = in_valid && in_ready;
        launch  = (state_q == LAUNCH) && ready_enc;
        fin     = (state_q == WAIT_DONE) && done_enc;
        drop    = to_hit && !done_enc;
        drain   = (state_q == OUTPUT) && out_ready;
        state_d = accept ? LAUNCH : launch ? WAIT_DONE : fin ? OUTPUT : (drop || drain) ? IDLE : state_q;
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // registered outputs, chaining value and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready    <= 1'b0;
            start       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            plain_text  <= '0;
            chain       <= '0;
            cbc_q       <= 1'b0;
            timeout_err <= 1'b0;
            blk_cnt     <= '0;
        end else begin
            in_ready <= state_d == IDLE;
            start    <= launch;
            if (accept) begin
                plain_text <= cbc_en ? in_data ^ (iv_load ? iv_in : chain) : in_data;
                cbc_q      <= cbc_en;
            end
            if (state_q == IDLE && iv_load) chain <= iv_in;
            else if (fin && cbc_q)          chain <= cipher_text;
            if (fin) begin
                out_data  <= cipher_text;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
                blk_cnt   <= blk_cnt + 32'd1;
            end
            timeout_err <= drop || (timeout_err && !clr_err);
        end
    end
endmodule

// File: tb/tb_aes_cbc_enc_ctrl.sv
// tb_aes_cbc_enc_ctrl: directed and random checks against a behavioural AES/CBC model
module tb_aes_cbc_enc_ctrl;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk, reset_n, cbc_en, iv_load, in_valid, in_ready, out_valid, out_ready;
    logic         start, ready_enc, done_enc, timeout_err, clr_err;
    logic [127:0] iv_in, in_data, out_data, plain_text, cipher_text;
    logic [31:0]  blk_cnt;

    int           checks = 0, failures = 0;
    logic [7:0]   sbox [256];
    logic [127:0] chain_m, pt_core;
    logic [31:0]  exp_cnt;
    logic         hang, spur, pending;
    int           dly_max, cdly;

    aes_cbc_enc_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cbc_en(cbc_en), .iv_load(iv_load), .iv_in(iv_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .plain_text(plain_text), .start(start),
        .ready_enc(ready_enc), .done_enc(done_enc), .cipher_text(cipher_text),
        .timeout_err(timeout_err), .clr_err(clr_err), .blk_cnt(blk_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] r;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    // stub encryption core: answers each start after a random delay unless told to hang
    initial begin
        done_enc = 0;
        cipher_text = '0;
        pending = 0;
        cdly = 0;
        forever begin
            @(negedge clk);
            done_enc = 0;
            cipher_text = {$urandom, $urandom, $urandom, $urandom};
            if (!reset_n) pending = 0;
            else if (pending) begin
                if (cdly == 0) begin
                    done_enc = 1;
                    cipher_text = aes_enc(KEY, pt_core);
                    pending = 0;
                end else cdly--;
            end else if (start && !hang) begin
                pending = 1;
                pt_core = plain_text;
                cdly = $urandom_range(0, dly_max);
            end else if (spur) begin
                done_enc = 1;
                spur = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [127:0] pt, input logic cbc, input logic ivl,
                         input logic [127:0] iv, output logic [127:0] e);
        if (ivl) chain_m = iv;
        e = aes_enc(KEY, cbc ? pt ^ chain_m : pt);
        if (cbc) chain_m = e;
    endtask

    task automatic send(input logic [127:0] pt, input logic cbc, input logic ivl, input logic [127:0] iv);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_in_ready", 128'(in_ready), 128'(1));
        in_valid = 1; in_data = pt; cbc_en = cbc; iv_load = ivl; iv_in = iv;
        @(negedge clk);
        in_valid = 0; iv_load = 0; cbc_en = 1'($urandom); in_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic recv(input logic [127:0] e, input string tag);
        int n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 128'(out_valid), 128'(1));
        check(tag, out_data, e);
        out_ready = 1;
        @(negedge clk);
        check({tag, "_valid_drop"}, 128'(out_valid), 128'(0));
    endtask

    task automatic xfer(input logic [127:0] pt, input logic cbc, input logic ivl, input logic [127:0] iv,
                        input logic [127:0] kat, input string tag);
        logic [127:0] e;
        model(pt, cbc, ivl, iv, e);
        if (kat != '0) begin
            e = kat;
            if (cbc) chain_m = kat;
        end
        send(pt, cbc, ivl, iv);
        recv(e, tag);
        exp_cnt++;
        check({tag, "_blk_cnt"}, 128'(blk_cnt), 128'(exp_cnt));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(0));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_start"}, 128'(start), 128'(0));
        check({tag, "_timeout_err"}, 128'(timeout_err), 128'(0));
        check({tag, "_blk_cnt"}, 128'(blk_cnt), 128'(0));
        check({tag, "_out_data"}, out_data, 128'(0));
        check({tag, "_plain_text"}, plain_text, 128'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [127:0] e, pt, v;
        logic [7:0]   inv, bv;
        int           cnt, starts;
        logic         sawv, sawe;
        for (int i = 0; i < 256; i++) begin
            bv = 8'(i);
            inv = 8'h00;
            for (int j = 1; j < 256; j++) if (gmul(bv, 8'(j)) == 8'h01) inv = 8'(j);
            sbox[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        reset_n = 0; cbc_en = 0; iv_load = 0; iv_in = '0; in_valid = 0; in_data = '0;
        out_ready = 1; ready_enc = 1; clr_err = 0; hang = 0; spur = 0; dly_max = 3;
        chain_m = '0; exp_cnt = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1;
        @(negedge clk);
        check("idle_in_ready", 128'(in_ready), 128'(1));

        // ECB known answer
        xfer(128'h3243f6a8885a308d313198a2e0370734, 0, 0, '0, 128'h3925841d02dc09fbdc118597196a0b32, "ecb_kat");

        // CBC known answers after a standalone IV load
        iv_load = 1; iv_in = 128'h000102030405060708090a0b0c0d0e0f;
        @(negedge clk);
        iv_load = 0;
        chain_m = 128'h000102030405060708090a0b0c0d0e0f;
        xfer(128'h6bc1bee22e409f96e93d7e117393172a, 1, 0, '0, 128'h7649abac8119b246cee98e9b12e9197d, "cbc_kat1");
        xfer(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1, 0, '0, 128'h5086cb9b507219ee95db113a917678b2, "cbc_kat2");

        // spurious done while idle is ignored
        spur = 1;
        repeat (4) @(negedge clk);
        check("spur_out_valid", 128'(out_valid), 128'(0));
        check("spur_blk_cnt", 128'(blk_cnt), 128'(exp_cnt));

        // back-pressure; an IV load while busy must not disturb the chain
        pt = {$urandom, $urandom, $urandom, $urandom};
        model(pt, 1, 0, '0, e);
        out_ready = 0;
        send(pt, 1, 0, '0);
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 20; i++) begin
            iv_load = (i == 3); iv_in = {$urandom, $urandom, $urandom, $urandom};
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_out_data", out_data, e);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            @(negedge clk);
        end
        iv_load = 0;
        recv(e, "bp");
        exp_cnt++;
        check("bp_blk_cnt", 128'(blk_cnt), 128'(exp_cnt));
        sawv = 0;
        repeat (5) begin
            @(negedge clk);
            sawv |= out_valid;
        end
        check("bp_single_beat", 128'(sawv), 128'(0));
        xfer({$urandom, $urandom, $urandom, $urandom}, 1, 0, '0, '0, "bp_chain");

        // launch gating on ready_enc
        ready_enc = 0;
        pt = {$urandom, $urandom, $urandom, $urandom};
        model(pt, 0, 0, '0, e);
        send(pt, 0, 0, '0);
        starts = 0;
        repeat (10) begin
            @(negedge clk);
            starts += int'(start);
        end
        check("gate_no_start", 128'(starts), 128'(0));
        check("gate_plain_text", plain_text, pt);
        ready_enc = 1;
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(negedge clk);
            starts += int'(start);
            cnt++;
        end
        check("gate_one_start", 128'(starts), 128'(1));
        recv(e, "gate");
        exp_cnt++;

        // timeout: block dropped, chain untouched, error sticky until cleared
        hang = 1;
        send({$urandom, $urandom, $urandom, $urandom}, 1, 0, '0);
        sawv = 0;
        repeat (55) begin
            @(negedge clk);
            sawv |= out_valid;
        end
        check("to_not_yet", 128'(timeout_err), 128'(0));
        repeat (20) begin
            @(negedge clk);
            sawv |= out_valid;
        end
        check("to_err_set", 128'(timeout_err), 128'(1));
        check("to_idle", 128'(in_ready), 128'(1));
        check("to_no_output", 128'(sawv), 128'(0));
        check("to_blk_cnt", 128'(blk_cnt), 128'(exp_cnt));
        @(negedge clk);
        check("to_err_sticky", 128'(timeout_err), 128'(1));
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
        check("to_err_clr", 128'(timeout_err), 128'(0));
        // clear held across a timeout: the set must still be visible
        clr_err = 1;
        send({$urandom, $urandom, $urandom, $urandom}, 0, 0, '0);
        sawe = 0;
        repeat (80) begin
            @(negedge clk);
            sawe |= timeout_err;
        end
        clr_err = 0;
        check("to_set_wins", 128'(sawe), 128'(1));
        check("to_cleared", 128'(timeout_err), 128'(0));
        hang = 0;
        xfer({$urandom, $urandom, $urandom, $urandom}, 1, 0, '0, '0, "after_to");

        // asynchronous reset while waiting on the core
        hang = 1;
        send({$urandom, $urandom, $urandom, $urandom}, 1, 0, '0);
        repeat (10) @(negedge clk);
        #2 reset_n = 0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        reset_n = 1;
        hang = 0;
        chain_m = '0;
        exp_cnt = 0;
        @(negedge clk);
        xfer(128'h3243f6a8885a308d313198a2e0370734, 0, 0, '0, 128'h3925841d02dc09fbdc118597196a0b32, "post_rst_ecb");
        xfer({$urandom, $urandom, $urandom, $urandom}, 1, 0, '0, '0, "post_rst_cbc");

        // random mix of modes, IV loads and core latencies
        for (int i = 0; i < 12; i++) begin
            dly_max = $urandom_range(0, 8);
            v = {$urandom, $urandom, $urandom, $urandom};
            xfer({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), ($urandom_range(0, 3) == 0), v, '0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
